// File: rtl/multicycle_controller_if.sv
// Control bundle between the multi-cycle MIPS controller and its datapath.
// The controller drives through the master modport; the datapath uses slave.
interface multicycle_controller_if;
   logic [5:0] opcode;
   logic [5:0] func;
   logic       zero;
   logic       pc_en;
   logic       iord;
   logic       memread;
   logic       memwrite;
   logic       irwrite;
   logic       regwrite;
   logic [1:0] regdst;
   logic [1:0] writedata_sel;
   logic       alusrca;
   logic [1:0] alusrcb;
   logic [2:0] aluoperation;
   logic [1:0] pcsrc;
   logic [3:0] state;

   modport master (
      input  opcode, func, zero,
      output pc_en, iord, memread, memwrite, irwrite, regwrite, regdst,
             writedata_sel, alusrca, alusrcb, aluoperation, pcsrc, state
   );

   modport slave (
      output opcode, func, zero,
      input  pc_en, iord, memread, memwrite, irwrite, regwrite, regdst,
             writedata_sel, alusrca, alusrcb, aluoperation, pcsrc, state
   );
endinterface

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing the shared-memory, single-ALU multi-cycle MIPS datapath.
// Control word is registered alongside the state; enables are masked while rst is high.
module multicycle_controller (
   input  logic                           clk,
   input  logic                           rst,
   multicycle_controller_if.master        bus
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD = 4'd3,
      S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_REXEC  = 4'd6,  S_RWB   = 4'd7,
      S_BRANCH = 4'd8,  S_JUMP   = 4'd9,  S_JAL    = 4'd10, S_JR    = 4'd11,
      S_IEXEC  = 4'd12, S_IWB    = 4'd13
   } state_t;

   typedef struct packed {
      logic       pcwrite;
      logic       pcwritecond;
      logic       iord;
      logic       memread;
      logic       memwrite;
      logic       irwrite;
      logic       regwrite;
      logic [1:0] regdst;
      logic [1:0] writedata_sel;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [2:0] aluoperation;
      logic [1:0] pcsrc;
   } ctrl_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;
   localparam logic [5:0] FN_JR  = 6'b001000;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   function automatic state_t next_state(input state_t s, input logic [5:0] op, input logic [5:0] fn);
      state_t n;
      n = S_FETCH;
      case (s)
         S_FETCH:  n = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_RTYPE: begin
                  case (fn)
                     FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: n = S_REXEC;
                     FN_JR:   n = S_JR;
                     default: n = S_FETCH;
                  endcase
               end
               OP_LW, OP_SW:     n = S_MEMADR;
               OP_BEQ:           n = S_BRANCH;
               OP_J:             n = S_JUMP;
               OP_JAL:           n = S_JAL;
               OP_ADDI, OP_SLTI: n = S_IEXEC;
               default:          n = S_FETCH;
            endcase
         end
         S_MEMADR: begin
            if (op == OP_LW) begin
               n = S_MEMRD;
            end else if (op == OP_SW) begin
               n = S_MEMWR;
            end else begin
               n = S_FETCH;
            end
         end
         S_MEMRD:  n = S_MEMWB;
         S_REXEC:  n = S_RWB;
         S_IEXEC:  n = S_IWB;
         default:  n = S_FETCH;
      endcase
      return n;
   endfunction

   // S6 and S12 pick the ALU operation from func/opcode, which IR holds steady.
   function automatic ctrl_t decode(input state_t s, input logic [5:0] op, input logic [5:0] fn);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH: begin
            c.memread = 1'b1; c.irwrite = 1'b1; c.alusrcb = 2'b01;
            c.aluoperation = ALU_ADD; c.pcwrite = 1'b1;
         end
         S_DECODE: begin
            c.alusrcb = 2'b11; c.aluoperation = ALU_ADD;
         end
         S_MEMADR: begin
            c.alusrca = 1'b1; c.alusrcb = 2'b10; c.aluoperation = ALU_ADD;
         end
         S_MEMRD: begin
            c.memread = 1'b1; c.iord = 1'b1;
         end
         S_MEMWB: begin
            c.writedata_sel = 2'b01; c.regwrite = 1'b1;
         end
         S_MEMWR: begin
            c.memwrite = 1'b1; c.iord = 1'b1;
         end
         S_REXEC: begin
            c.alusrca = 1'b1;
            case (fn)
               FN_ADD:  c.aluoperation = ALU_ADD;
               FN_SUB:  c.aluoperation = ALU_SUB;
               FN_AND:  c.aluoperation = ALU_AND;
               FN_OR:   c.aluoperation = ALU_OR;
               FN_SLT:  c.aluoperation = ALU_SLT;
               default: c.aluoperation = ALU_AND;
            endcase
         end
         S_RWB: begin
            c.regdst = 2'b01; c.regwrite = 1'b1;
         end
         S_BRANCH: begin
            c.alusrca = 1'b1; c.aluoperation = ALU_SUB; c.pcsrc = 2'b01; c.pcwritecond = 1'b1;
         end
         S_JUMP: begin
            c.pcsrc = 2'b10; c.pcwrite = 1'b1;
         end
         S_JAL: begin
            c.pcsrc = 2'b10; c.pcwrite = 1'b1; c.regdst = 2'b10;
            c.writedata_sel = 2'b10; c.regwrite = 1'b1;
         end
         S_JR: begin
            c.pcsrc = 2'b11; c.pcwrite = 1'b1;
         end
         S_IEXEC: begin
            c.alusrca = 1'b1; c.alusrcb = 2'b10;
            if (op == OP_SLTI) begin
               c.aluoperation = ALU_SLT;
            end else begin
               c.aluoperation = ALU_ADD;
            end
         end
         S_IWB: begin
            c.regwrite = 1'b1;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

   state_t state_r;
   ctrl_t  ctrl_r;
   state_t nxt_s;

   assign nxt_s = next_state(state_r, bus.opcode, bus.func);

   // State and its control word advance together so outputs stay glitch-free.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= S_FETCH;
         ctrl_r  <= decode(S_FETCH, 6'd0, 6'd0);
      end else begin
         state_r <= nxt_s;
         ctrl_r  <= decode(nxt_s, bus.opcode, bus.func);
      end
   end

   // Enables are masked by rst so a held reset never fetches or writes.
   assign bus.pc_en         = ~rst & (ctrl_r.pcwrite | (ctrl_r.pcwritecond & bus.zero));
   assign bus.memread       = ~rst & ctrl_r.memread;
   assign bus.memwrite      = ~rst & ctrl_r.memwrite;
   assign bus.irwrite       = ~rst & ctrl_r.irwrite;
   assign bus.regwrite      = ~rst & ctrl_r.regwrite;
   assign bus.iord          = ctrl_r.iord;
   assign bus.regdst        = ctrl_r.regdst;
   assign bus.writedata_sel = ctrl_r.writedata_sel;
   assign bus.alusrca       = ctrl_r.alusrca;
   assign bus.alusrcb       = ctrl_r.alusrcb;
   assign bus.aluoperation  = ctrl_r.aluoperation;
   assign bus.pcsrc         = ctrl_r.pcsrc;
   assign bus.state         = state_r;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: stimulus queues per-cycle expected
// control words, a negedge monitor pops and compares them.
module tb_multicycle_controller;

   logic clk;
   logic rst;

   multicycle_controller_if bus ();

   multicycle_controller dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      string       name;
      logic [21:0] v;
   } exp_t;

   exp_t q[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected control word {state, pc_en, iord, memread, memwrite, irwrite, regwrite,
   // regdst, writedata_sel, alusrca, alusrcb, aluoperation, pcsrc}, taken from the state table.
   function automatic logic [21:0] expv(input logic [3:0] s, input logic [5:0] op,
                                        input logic [5:0] fn, input logic z, input logic r);
      logic pcw, pcc, io, mr, mw, irw, rw, a;
      logic [1:0] rd, ws, bs, ps;
      logic [2:0] alu;
      pcw = 1'b0; pcc = 1'b0; io = 1'b0; mr = 1'b0; mw = 1'b0; irw = 1'b0; rw = 1'b0; a = 1'b0;
      rd = 2'b00; ws = 2'b00; bs = 2'b00; ps = 2'b00; alu = 3'b000;
      case (s)
         4'd0:  begin mr = 1'b1; irw = 1'b1; bs = 2'b01; alu = 3'b010; pcw = 1'b1; end
         4'd1:  begin bs = 2'b11; alu = 3'b010; end
         4'd2:  begin a = 1'b1; bs = 2'b10; alu = 3'b010; end
         4'd3:  begin mr = 1'b1; io = 1'b1; end
         4'd4:  begin ws = 2'b01; rw = 1'b1; end
         4'd5:  begin mw = 1'b1; io = 1'b1; end
         4'd6:  begin
            a = 1'b1;
            if (fn == 6'b100000) alu = 3'b010;
            else if (fn == 6'b100010) alu = 3'b110;
            else if (fn == 6'b100101) alu = 3'b001;
            else if (fn == 6'b101010) alu = 3'b111;
            else alu = 3'b000;
         end
         4'd7:  begin rd = 2'b01; rw = 1'b1; end
         4'd8:  begin a = 1'b1; alu = 3'b110; ps = 2'b01; pcc = 1'b1; end
         4'd9:  begin ps = 2'b10; pcw = 1'b1; end
         4'd10: begin ps = 2'b10; pcw = 1'b1; rd = 2'b10; ws = 2'b10; rw = 1'b1; end
         4'd11: begin ps = 2'b11; pcw = 1'b1; end
         4'd12: begin a = 1'b1; bs = 2'b10; alu = (op == 6'b001010) ? 3'b111 : 3'b010; end
         4'd13: begin rw = 1'b1; end
         default: ;
      endcase
      return {s, (pcw | (pcc & z)) & ~r, io, mr & ~r, mw & ~r, irw & ~r, rw & ~r,
              rd, ws, a, bs, alu, ps};
   endfunction

   task automatic push(input string name, input logic [21:0] v);
      exp_t e;
      e.name = name;
      e.v    = v;
      q.push_back(e);
   endtask

   // Monitor: the DUT presents a control word every cycle; compare mid-cycle.
   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         logic [21:0] act;
         e = q.pop_front();
         act = {bus.state, bus.pc_en, bus.iord, bus.memread, bus.memwrite, bus.irwrite,
                bus.regwrite, bus.regdst, bus.writedata_sel, bus.alusrca, bus.alusrcb,
                bus.aluoperation, bus.pcsrc};
         n_cmp++;
         if (act !== e.v) begin
            n_fail++;
            $display("FAIL %s: actual %06h required %06h", e.name, act, e.v);
         end
      end
   end

   // Runs one instruction: seq holds the expected state nibbles MSB-first.
   task automatic instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                        input logic z, input logic [23:0] seq, input int n);
      bus.opcode = op;
      bus.func   = fn;
      bus.zero   = z;
      for (int i = 0; i < n; i++) begin
         logic [3:0] s;
         s = seq[23-4*i -: 4];
         push($sformatf("%s c%0d s%0d", tag, i, s), expv(s, op, fn, z, rst));
         @(posedge clk); #1;
      end
   endtask

   task automatic check_now(input string name, input logic [7:0] act, input logic [7:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", name, act, req);
      end
   endtask

   initial begin
      rst        = 1'b1;
      bus.opcode = 6'd0;
      bus.func   = 6'd0;
      bus.zero   = 1'b0;

      @(posedge clk); #1;
      push("reset c0", expv(4'd0, 6'd0, 6'd0, 1'b0, 1'b1));
      @(posedge clk); #1;
      push("reset c1", expv(4'd0, 6'd0, 6'd0, 1'b0, 1'b1));
      @(posedge clk); #1;
      rst = 1'b0;

      instr("lw",      6'b100011, 6'b000000, 1'b0, 24'h012340, 5);
      instr("sw",      6'b101011, 6'b000000, 1'b0, 24'h012500, 4);
      instr("add",     6'b000000, 6'b100000, 1'b0, 24'h016700, 4);
      instr("sub",     6'b000000, 6'b100010, 1'b0, 24'h016700, 4);
      instr("slt",     6'b000000, 6'b101010, 1'b0, 24'h016700, 4);
      instr("beq_tk",  6'b000100, 6'b000000, 1'b1, 24'h018000, 3);
      instr("beq_nt",  6'b000100, 6'b000000, 1'b0, 24'h018000, 3);
      instr("jal",     6'b000011, 6'b000000, 1'b0, 24'h01a000, 3);
      instr("jr",      6'b000000, 6'b001000, 1'b0, 24'h01b000, 3);
      instr("addi",    6'b001000, 6'b000000, 1'b0, 24'h01cd00, 4);
      instr("slti",    6'b001010, 6'b000000, 1'b0, 24'h01cd00, 4);
      instr("j",       6'b000010, 6'b000000, 1'b0, 24'h019000, 3);
      instr("illop",   6'b111111, 6'b000000, 1'b0, 24'h010000, 2);
      instr("illfn",   6'b000000, 6'b111111, 1'b0, 24'h010000, 2);

      // lw interrupted by reset while in S3
      instr("lwrst",   6'b100011, 6'b000000, 1'b0, 24'h012000, 3);
      push("lwrst s3", expv(4'd3, 6'b100011, 6'd0, 1'b0, 1'b0));
      @(negedge clk); #1;
      rst = 1'b1;
      #1;
      check_now("async_state", {4'd0, bus.state}, 8'd0);
      check_now("async_enables",
                {3'd0, bus.pc_en, bus.memread, bus.memwrite, bus.irwrite, bus.regwrite}, 8'd0);
      @(posedge clk); #1;
      push("lwrst held", expv(4'd0, 6'b100011, 6'd0, 1'b0, 1'b1));
      @(posedge clk); #1;
      rst = 1'b0;

      instr("after",   6'b000010, 6'b000000, 1'b0, 24'h019000, 3);
      push("final s0", expv(4'd0, 6'b000010, 6'd0, 1'b0, 1'b0));

      for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
      if (q.size() > 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL drain: actual %0d pending required 0", q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
